// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_e;

  // Bit-index counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_w(input int width);
    int w;
    w = $clog2(width);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/sa_fa_cell.sv
// Single 1-bit full-adder cell; the only arithmetic element of the serial adder.
module sa_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);

  logic p;

  assign p = a ^ b;
  assign s = p ^ cin;
  assign c = (a & b) | (p & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell stepped LSB-first over WIDTH cycles.
// Optional signed-overflow output ovf_o is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             busy_o
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int CW = cnt_w(WIDTH);

  sa_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cell_s, cell_c;
  logic             last_bit;
  logic             req_fire, resp_fire;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  sa_fa_cell u_cell (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .cin (carry_q),
    .s   (cell_s),
    .c   (cell_c)
  );

  assign last_bit  = (cnt_q == CW'(WIDTH - 1));
  assign req_fire  = req_valid_i & (state_q == IDLE);
  assign resp_fire = resp_ready_i & (state_q == DONE);

  // Next-state logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (resp_fire) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, shift one bit per RUN cycle, hold everywhere else.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          a_d     = a_i;
          b_d     = b_i;
          carry_d = cin_i;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d   = cnt_q;
        end
      end
      RUN: begin
        a_d            = a_q >> 1'b1;
        b_d            = b_q >> 1'b1;
        sum_d          = sum_q >> 1'b1;
        sum_d[WIDTH-1] = cell_s;
        carry_d        = cell_c;
        cnt_d          = cnt_q + CW'(1);
        // On the MSB step carry_q is the carry into the MSB.
        if (last_bit) begin
          cout_d = cell_c;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d  = carry_q ^ cell_c;
`endif
        end else begin
          cout_d = cout_q;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= {CW{1'b0}};
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = (state_q == DONE);
  assign busy_o       = (state_q == RUN) | (state_q == DONE);
  assign sum_o        = sum_q;
  assign cout_o       = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf_o        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: WIDTH=8 directed/random ops and WIDTH=1 exhaustive.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, cin_in, resp_valid, resp_ready, cout, busy;
  logic [7:0] a_in, b_in, sum;
  logic       r1_req_valid, r1_req_ready, r1_cin, r1_resp_valid, r1_resp_ready, r1_cout, r1_busy;
  logic [0:0] r1_a, r1_b, r1_sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf, r1_ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .a_i(a_in), .b_i(b_in), .cin_i(cin_in), .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready), .sum_o(sum), .cout_o(cout), .busy_o(busy)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf_o(ovf)
`endif
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk_i(clk), .reset_i(reset), .req_valid_i(r1_req_valid), .req_ready_o(r1_req_ready),
    .a_i(r1_a), .b_i(r1_b), .cin_i(r1_cin), .resp_valid_o(r1_resp_valid),
    .resp_ready_i(r1_resp_ready), .sum_o(r1_sum), .cout_o(r1_cout), .busy_o(r1_busy)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf_o(r1_ovf)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b expected 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b expected 0", resp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b expected 0", busy); end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL rst_sum got %h expected 00", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL rst_cout got %b expected 0", cout); end
    checks++; if (r1_req_ready !== 1'b1 || r1_resp_valid !== 1'b0 || r1_busy !== 1'b0) begin
      errors++; $display("FAIL rst_w1 got rdy=%b vld=%b busy=%b expected 1 0 0", r1_req_ready, r1_resp_valid, r1_busy);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b expected 0", ovf); end
`endif
  endtask

  // Full transaction on the WIDTH=8 instance; poke holds a competing request during the stall.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input int stall, input bit poke, input string tag);
    logic [8:0] full;
    logic       exp_ovf;
    int         n;
    full    = {1'b0, a} + {1'b0, b} + {8'd0, c};
    exp_ovf = (a[7] == b[7]) && (full[7] != a[7]);
    req_valid = 1'b1; a_in = a; b_in = b; cin_in = c;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL %s_req_ready got %b expected 1", tag, req_ready); end
    step();
    req_valid = 1'b0; a_in = 8'($urandom); b_in = 8'($urandom); cin_in = 1'($urandom);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy got %b expected 1", tag, busy); end
    n = 0;
    while (resp_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL %s_latency got %0d edges expected 8", tag, n); end
    checks++; if (sum !== full[7:0]) begin errors++; $display("FAIL %s_sum got %h expected %h", tag, sum, full[7:0]); end
    checks++; if (cout !== full[8]) begin errors++; $display("FAIL %s_cout got %b expected %b", tag, cout, full[8]); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL %s_ready_in_done got %b expected 0", tag, req_ready); end
`ifdef SERIAL_ADDER_OVF_EN
    checks++; if (ovf !== exp_ovf) begin errors++; $display("FAIL %s_ovf got %b expected %b", tag, ovf, exp_ovf); end
`endif
    for (int s = 0; s < stall; s++) begin
      if (poke) begin
        req_valid = 1'b1; a_in = 8'($urandom); b_in = 8'($urandom);
      end
      step();
      checks++; if (resp_valid !== 1'b1 || sum !== full[7:0] || cout !== full[8]) begin
        errors++; $display("FAIL %s_hold got vld=%b sum=%h cout=%b expected 1 %h %b", tag, resp_valid, sum, cout, full[7:0], full[8]);
      end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL %s_hold_ready got %b expected 0", tag, req_ready); end
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL %s_release got vld=%b busy=%b rdy=%b expected 0 0 1", tag, resp_valid, busy, req_ready);
    end
    checks++; if (sum !== full[7:0]) begin errors++; $display("FAIL %s_idle_sum got %h expected %h", tag, sum, full[7:0]); end
  endtask

  task automatic test_directed();
    do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0, "ff_01");
    do_op(8'hA5, 8'h5A, 1'b1, 1, 1'b0, "a5_5a");
    do_op(8'h12, 8'h34, 1'b0, 0, 1'b0, "12_34");
    do_op(8'h7F, 8'h01, 1'b0, 0, 1'b0, "7f_01");
    do_op(8'h80, 8'h80, 1'b0, 0, 1'b0, "80_80");
  endtask

  task automatic test_backpressure();
    do_op(8'h9C, 8'h3D, 1'b1, 5, 1'b1, "bp");
  endtask

  task automatic test_reset_midrun();
    req_valid = 1'b1; a_in = 8'h33; b_in = 8'h44; cin_in = 1'b0;
    step();
    req_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_ctrl got rdy=%b vld=%b busy=%b expected 1 0 0", req_ready, resp_valid, busy);
    end
    checks++; if (sum !== 8'h00 || cout !== 1'b0) begin
      errors++; $display("FAIL midrst_data got sum=%h cout=%b expected 00 0", sum, cout);
    end
    do_op(8'h01, 8'h01, 1'b0, 0, 1'b0, "after_rst");
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom), "rand");
    end
  endtask

  task automatic test_width1();
    logic [1:0] full;
    logic       a, b, c, exp_ovf;
    int         n;
    for (int i = 0; i < 8; i++) begin
      a = i[0]; b = i[1]; c = i[2];
      full    = {1'b0, a} + {1'b0, b} + {1'b0, c};
      exp_ovf = (a == b) && (full[0] != a);
      r1_req_valid = 1'b1; r1_a = a; r1_b = b; r1_cin = c;
      step();
      r1_req_valid = 1'b0;
      n = 0;
      while (r1_resp_valid !== 1'b1 && n < 10) begin
        step();
        n++;
      end
      checks++; if (n !== 1) begin errors++; $display("FAIL w1_latency_%0d got %0d expected 1", i, n); end
      checks++; if (r1_sum !== full[0:0] || r1_cout !== full[1]) begin
        errors++; $display("FAIL w1_result_%0d got sum=%b cout=%b expected %b %b", i, r1_sum, r1_cout, full[0], full[1]);
      end
`ifdef SERIAL_ADDER_OVF_EN
      checks++; if (r1_ovf !== exp_ovf) begin errors++; $display("FAIL w1_ovf_%0d got %b expected %b", i, r1_ovf, exp_ovf); end
`endif
      r1_resp_ready = 1'b1;
      step();
      r1_resp_ready = 1'b0;
      checks++; if (r1_req_ready !== 1'b1 || r1_busy !== 1'b0) begin
        errors++; $display("FAIL w1_release_%0d got rdy=%b busy=%b expected 1 0", i, r1_req_ready, r1_busy);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; a_in = 8'h00; b_in = 8'h00; cin_in = 1'b0;
    r1_req_valid = 1'b0; r1_resp_ready = 1'b0; r1_a = 1'b0; r1_b = 1'b0; r1_cin = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midrun();
    test_random();
    test_width1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
